// File: rtl/seven_segment_capture.sv
// Captures a multiplexed active-low 4-digit seven-segment display and rebuilds the shown value.
// Optional SEGCAP_ERR_CNT_EN builds a saturating frame-error counter on err_cnt.
module seven_segment_capture #(
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT       = 65536,
    parameter int POINT_W       = 14
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         display,
    input  logic [3:0]         digit,
    output logic [POINT_W-1:0] point,
    output logic               point_valid,
    output logic               frame_err,
    output logic [7:0]         err_cnt
);

    localparam int SC_W = $clog2(STABLE_CYCLES);
    localparam int TO_W = $clog2(TIMEOUT);

    typedef enum logic [1:0] {HUNT, COLLECT, CONVERT, DONE} state_t;

    logic [6:0]         disp_s1, disp_s2, disp_p;
    logic [3:0]         dig_s1, dig_s2, dig_p;
    logic [SC_W-1:0]    stab_cnt;
    state_t             state;
    logic [1:0]         expect_idx;
    logic [1:0]         conv_step;
    logic [TO_W-1:0]    to_cnt;
    logic [3:0][3:0]    store;
    logic [POINT_W-1:0] acc;

    logic               strobe, changed, sample;
    logic               idx_ok, dec_err;
    logic [1:0]         idx;
    logic [3:0]         dec_val, conv_digit;
    logic [POINT_W-1:0] mac;

    assign strobe  = (dig_s2 != 4'hF);
    assign changed = (disp_s2 != disp_p) || (dig_s2 != dig_p);
    assign sample  = strobe && !changed && (stab_cnt == SC_W'(STABLE_CYCLES - 2));

    always_comb begin
        idx    = 2'd0;
        idx_ok = 1'b1;
        case (dig_s2)
            4'b1110: idx = 2'd0;
            4'b1101: idx = 2'd1;
            4'b1011: idx = 2'd2;
            4'b0111: idx = 2'd3;
            default: idx_ok = 1'b0;
        endcase
    end

    always_comb begin
        dec_val = 4'd0;
        dec_err = 1'b0;
        case (disp_s2)
            7'b1000000: dec_val = 4'd0;
            7'b1111001: dec_val = 4'd1;
            7'b0100100: dec_val = 4'd2;
            7'b0110000: dec_val = 4'd3;
            7'b0011001: dec_val = 4'd4;
            7'b0010010: dec_val = 4'd5;
            7'b0000010: dec_val = 4'd6;
            7'b1111000: dec_val = 4'd7;
            7'b0000000: dec_val = 4'd8;
            7'b0010000: dec_val = 4'd9;
            7'b1111111: dec_val = 4'd0;
            default:    dec_err = 1'b1;
        endcase
    end

    assign conv_digit = store[2'd3 - conv_step];
    assign mac        = acc * POINT_W'(10) + POINT_W'(conv_digit);

    // Sync flops clear to the idle bus level (all segments off, no strobe) so
    // reset release cannot look like a stable illegal strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_s1  <= 7'h7F;
            disp_s2  <= 7'h7F;
            disp_p   <= 7'h7F;
            dig_s1   <= 4'hF;
            dig_s2   <= 4'hF;
            dig_p    <= 4'hF;
            stab_cnt <= '0;
        end else begin
            disp_s1 <= display;
            disp_s2 <= disp_s1;
            disp_p  <= disp_s2;
            dig_s1  <= digit;
            dig_s2  <= dig_s1;
            dig_p   <= dig_s2;
            if (!strobe || changed)
                stab_cnt <= '0;
            else if (stab_cnt != SC_W'(STABLE_CYCLES - 1))
                stab_cnt <= stab_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            expect_idx  <= 2'd0;
            conv_step   <= 2'd0;
            to_cnt      <= '0;
            store       <= '0;
            acc         <= '0;
            point       <= '0;
            point_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            point_valid <= 1'b0;
            frame_err   <= 1'b0;
            case (state)
                HUNT: begin
                    if (sample && !idx_ok) begin
                        frame_err <= 1'b1;
                    end else if (sample && idx == 2'd0 && !dec_err) begin
                        store[0]   <= dec_val;
                        expect_idx <= 2'd1;
                        to_cnt     <= '0;
                        state      <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (sample) begin
                        if (!idx_ok || dec_err) begin
                            frame_err <= 1'b1;
                            state     <= HUNT;
                        end else if (idx == expect_idx) begin
                            store[idx] <= dec_val;
                            expect_idx <= expect_idx + 2'd1;
                            to_cnt     <= '0;
                            if (idx == 2'd3) begin
                                acc       <= '0;
                                conv_step <= 2'd0;
                                state     <= CONVERT;
                            end
                        end else if (idx == expect_idx - 2'd1) begin
                            // Same strobe re-settled: newest pattern wins.
                            store[idx] <= dec_val;
                            to_cnt     <= '0;
                        end else if (idx == 2'd0) begin
                            frame_err  <= 1'b1;
                            store[0]   <= dec_val;
                            expect_idx <= 2'd1;
                            to_cnt     <= '0;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= HUNT;
                        end
                    end else if (to_cnt == TO_W'(TIMEOUT - 1)) begin
                        frame_err <= 1'b1;
                        state     <= HUNT;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                CONVERT: begin
                    if (conv_step == 2'd3) begin
                        point       <= mac;
                        point_valid <= 1'b1;
                        state       <= DONE;
                    end else begin
                        acc       <= mac;
                        conv_step <= conv_step + 2'd1;
                    end
                end
                DONE: state <= HUNT;
                default: state <= HUNT;
            endcase
        end
    end

`ifdef SEGCAP_ERR_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_cnt <= 8'd0;
        else if (frame_err && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'd1;
    end
`else
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_seven_segment_capture.sv
// Directed bench for seven_segment_capture: frames, glitch rejection, aborts, timeout, reset.
module tb_seven_segment_capture;

    localparam logic [3:0] D0 = 4'b1110, D1 = 4'b1101, D2 = 4'b1011, D3 = 4'b0111;
    localparam logic [3:0] NONE = 4'b1111;
    localparam logic [6:0] BLANK = 7'b1111111, DASH = 7'b0111111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  display = BLANK;
    logic [3:0]  digit = NONE;
    logic [13:0] point;
    logic        point_valid, frame_err;
    logic [7:0]  err_cnt;

    logic [6:0]  seg [10];
    int          checks = 0;
    int          errors = 0;
    int          pv_cnt = 0, fe_cnt = 0, both_cnt = 0;
    int          pv_base, fe_base, lat;

    seven_segment_capture #(.STABLE_CYCLES(4), .TIMEOUT(32), .POINT_W(14)) dut (
        .clk(clk), .rst_n(rst_n), .display(display), .digit(digit),
        .point(point), .point_valid(point_valid), .frame_err(frame_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (point_valid) pv_cnt <= pv_cnt + 1;
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (point_valid && frame_err) both_cnt <= both_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic show(input logic [3:0] d, input logic [6:0] s, input int n);
        digit   = d;
        display = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [6:0] s3, input logic [6:0] s2,
                         input logic [6:0] s1, input logic [6:0] s0);
        show(D0, s0, 16);
        show(D1, s1, 16);
        show(D2, s2, 16);
        show(D3, s3, 16);
        show(NONE, BLANK, 8);
    endtask

`ifdef SEGCAP_ERR_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    initial begin
        seg = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        repeat (3) @(posedge clk);
        #1;
        chk("reset_point", point, 0);
        chk("reset_point_valid", point_valid, 0);
        chk("reset_frame_err", frame_err, 0);
        chk("reset_err_cnt", err_cnt, 0);
        rst_n = 1'b1;
        show(NONE, BLANK, 4);

        // 1234, with latency measured from the thousands strobe drive
        pv_base = pv_cnt; fe_base = fe_cnt;
        show(D0, seg[4], 16);
        show(D1, seg[3], 16);
        show(D2, seg[2], 16);
        digit = D3; display = seg[1];
        lat = 0;
        while (!point_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency_1234", lat, 10);
        chk("point_1234", point, 1234);
        show(D3, seg[1], 6);
        show(NONE, BLANK, 8);
        chk("pv_pulses_1234", pv_cnt - pv_base, 1);
        chk("fe_pulses_1234", fe_cnt - fe_base, 0);
        chk("pv_low_after", point_valid, 0);

        // Segments toggling every 2 cycles never settle
        pv_base = pv_cnt; fe_base = fe_cnt;
        for (int i = 0; i < 20; i++) show(D0, (i % 2 == 0) ? seg[4] : seg[5], 2);
        show(NONE, BLANK, 8);
        chk("toggle_pv", pv_cnt - pv_base, 0);
        chk("toggle_fe", fe_cnt - fe_base, 0);
        chk("toggle_point", point, 1234);

        // Skipped tens strobe aborts, then a blank-led 0042 frame
        fe_base = fe_cnt;
        show(D0, seg[5], 16);
        show(D2, seg[3], 16);
        show(NONE, BLANK, 8);
        chk("skip_fe", fe_cnt - fe_base, 1);
        chk("skip_point", point, 1234);
        pv_base = pv_cnt;
        frame(BLANK, BLANK, seg[4], seg[2]);
        chk("point_0042", point, 42);
        chk("pv_0042", pv_cnt - pv_base, 1);

        // Dash on tens is a decode error
        fe_base = fe_cnt;
        show(D0, seg[7], 16);
        show(D1, DASH, 16);
        show(NONE, BLANK, 8);
        chk("dash_fe", fe_cnt - fe_base, 1);
        chk("dash_err_cnt", err_cnt, CNT_ON ? 2 : 0);
        chk("dash_point", point, 42);

        // Strobes stop after tens: timeout abort
        fe_base = fe_cnt;
        show(D0, seg[1], 16);
        show(D1, seg[2], 16);
        show(NONE, BLANK, 10);
        chk("timeout_not_yet", fe_cnt - fe_base, 0);
        show(NONE, BLANK, 30);
        chk("timeout_fe", fe_cnt - fe_base, 1);
        chk("timeout_point", point, 42);
        chk("timeout_err_cnt", err_cnt, CNT_ON ? 3 : 0);

        // Reset asserted during conversion of 9999
        pv_base = pv_cnt;
        show(D0, seg[9], 16);
        show(D1, seg[9], 16);
        show(D2, seg[9], 16);
        show(D3, seg[9], 7);
        rst_n = 1'b0;
        #1;
        chk("async_rst_point", point, 0);
        chk("async_rst_err_cnt", err_cnt, 0);
        show(NONE, BLANK, 3);
        rst_n = 1'b1;
        show(NONE, BLANK, 6);
        chk("rst_no_pv", pv_cnt - pv_base, 0);
        frame(seg[9], seg[9], seg[9], seg[9]);
        chk("point_9999", point, 9999);

        // 300 illegal strobe codes
        fe_base = fe_cnt;
        for (int i = 0; i < 300; i++) begin
            show(4'b1100, BLANK, 8);
            show(NONE, BLANK, 4);
        end
        chk("illegal_fe", fe_cnt - fe_base, 300);
        chk("sat_err_cnt", err_cnt, CNT_ON ? 255 : 0);
        chk("sat_point", point, 9999);
        chk("never_both", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
